// File: rtl/mgmt_gpio_in_sampler_pkg.sv
// Shared defaults and width helpers for the management GPIO input sampler.
// NBITS_DEF  : number of management GPIO inputs
// DB_DIV_DEF : clocks between debounce ticks
// DB_CNT_DEF : consecutive mismatching ticks before the filtered level flips
package mgmt_gpio_pkg;

  localparam int unsigned NBITS_DEF  = 19;
  localparam int unsigned DB_DIV_DEF = 16;
  localparam int unsigned DB_CNT_DEF = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mgmt_gpio_in_sampler_if.sv
// Bus between the housekeeping register block (master) and the input sampler (slave).
// gpio_in_buf : buffered pad inputs, asynchronous to the sampler clock
// db_en       : per-bit debounce enable
// rise_en     : per-bit rising-edge capture enable
// fall_en     : per-bit falling-edge capture enable
// pend_clr    : one-cycle write-1-to-clear strobe for pend
// gpio_val    : synchronised, filtered level
// pend        : sticky edge-pending flags
// irq         : OR of pend
interface mgmt_gpio_in_sampler_if
  import mgmt_gpio_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF
) ();

  logic [NBITS-1:0] gpio_in_buf;
  logic [NBITS-1:0] db_en;
  logic [NBITS-1:0] rise_en;
  logic [NBITS-1:0] fall_en;
  logic [NBITS-1:0] pend_clr;
  logic [NBITS-1:0] gpio_val;
  logic [NBITS-1:0] pend;
  logic             irq;

  modport master (
    output gpio_in_buf, db_en, rise_en, fall_en, pend_clr,
    input  gpio_val, pend, irq
  );

  modport slave (
    input  gpio_in_buf, db_en, rise_en, fall_en, pend_clr,
    output gpio_val, pend, irq
  );

endinterface

// File: rtl/mgmt_gpio_in_sampler_debounce_bit.sv
// One input bit: two-flop synchroniser, optional tick-based debounce filter,
// and combinational rise/fall indications derived from the next filtered level.
// wb_clk_i, wb_rstn_i : clock and synchronous active-low reset
// pad                 : asynchronous pad input
// db_en               : 1 = debounce, 0 = filtered level follows the synchroniser
// tick                : shared prescaler tick
// filt                : registered filtered level
// rise_c / fall_c     : filtered level is about to rise / fall at the next edge
module gpio_in_debounce_bit
  import mgmt_gpio_pkg::*;
#(
  parameter int unsigned DB_CNT = DB_CNT_DEF
) (
  input  logic wb_clk_i,
  input  logic wb_rstn_i,
  input  logic pad,
  input  logic db_en,
  input  logic tick,
  output logic filt,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = cnt_width(DB_CNT);

  logic          s1;
  logic          s2;
  logic          filt_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Filter decision: bypass, restart on agreement, or count mismatching ticks.
  always_comb begin
    filt_next = filt;
    cnt_next  = cnt;
    if (!db_en) begin
      filt_next = s2;
      cnt_next  = '0;
    end else if (s2 == filt) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt == CW'(DB_CNT - 1)) begin
        filt_next = s2;
        cnt_next  = '0;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  assign rise_c = filt_next & ~filt;
  assign fall_c = ~filt_next & filt;

  // Synchroniser, filtered level and stable counter.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= pad;
      s2   <= s1;
      filt <= filt_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/mgmt_gpio_in_sampler.sv
// Management GPIO input sampler: per-bit synchronise/debounce, edge capture into
// sticky write-1-to-clear pending flags, and a level interrupt.
// wb_clk_i  : block clock
// wb_rstn_i : synchronous active-low reset
// bus       : slave side of mgmt_gpio_in_sampler_if (inputs, enables, pend/irq)
module mgmt_gpio_in_sampler
  import mgmt_gpio_pkg::*;
#(
  parameter int unsigned NBITS  = NBITS_DEF,
  parameter int unsigned DB_DIV = DB_DIV_DEF,
  parameter int unsigned DB_CNT = DB_CNT_DEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rstn_i,
  mgmt_gpio_in_sampler_if.slave  bus
);

  localparam int unsigned PW = cnt_width(DB_DIV);

  logic [PW-1:0]    presc;
  logic             tick;
  logic [NBITS-1:0] filt;
  logic [NBITS-1:0] rise_c;
  logic [NBITS-1:0] fall_c;
  logic [NBITS-1:0] pend;
  logic [NBITS-1:0] pend_next;
  logic             irq;

  assign tick = (presc == PW'(DB_DIV - 1));

  // Debounce prescaler, wrapping at DB_DIV-1.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  for (genvar i = 0; i < int'(NBITS); i++) begin : g_bit
    gpio_in_debounce_bit #(
      .DB_CNT (DB_CNT)
    ) u_bit (
      .wb_clk_i  (wb_clk_i),
      .wb_rstn_i (wb_rstn_i),
      .pad       (bus.gpio_in_buf[i]),
      .db_en     (bus.db_en[i]),
      .tick      (tick),
      .filt      (filt[i]),
      .rise_c    (rise_c[i]),
      .fall_c    (fall_c[i])
    );
  end

  // A new edge outranks a clear on the same bit.
  assign pend_next = (pend & ~bus.pend_clr)
                   | (rise_c & bus.rise_en)
                   | (fall_c & bus.fall_en);

  // irq is registered from pend_next so it tracks pend with no extra cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      pend <= '0;
      irq  <= 1'b0;
    end else begin
      pend <= pend_next;
      irq  <= |pend_next;
    end
  end

  assign bus.gpio_val = filt;
  assign bus.pend     = pend;
  assign bus.irq      = irq;

endmodule

// File: tb/tb_mgmt_gpio_in_sampler.sv
// Self-checking bench for mgmt_gpio_in_sampler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_mgmt_gpio_in_sampler;
  import mgmt_gpio_pkg::*;

  localparam int unsigned NB  = NBITS_DEF;
  localparam int          DIV = int'(DB_DIV_DEF);
  localparam int          CNT = int'(DB_CNT_DEF);

  typedef logic [NB-1:0] vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mgmt_gpio_in_sampler_if #(.NBITS(NB)) bus ();

  mgmt_gpio_in_sampler #(
    .NBITS  (NB),
    .DB_DIV (DB_DIV_DEF),
    .DB_CNT (DB_CNT_DEF)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rstn),
    .bus       (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: level seen by the filter is the input from two edges ago;
  // a debounced bit flips once the disagreement has lasted CNT ticks, where a
  // tick is every DIV-th clock counted from reset release.
  vec_t m_val, m_pend, m_in1, m_in2, nv;
  int   m_run [NB];
  int   age;
  bit   m_tick;

  always @(posedge clk) begin
    if (!rstn) begin
      m_val  = '0;
      m_pend = '0;
      m_in1  = '0;
      m_in2  = '0;
      age    = 0;
      for (int i = 0; i < int'(NB); i++) m_run[i] = 0;
    end else begin
      m_tick = ((age % DIV) == DIV - 1);
      nv = m_val;
      for (int i = 0; i < int'(NB); i++) begin
        if (!bus.db_en[i]) begin
          nv[i] = m_in2[i];
          m_run[i] = 0;
        end else if (m_in2[i] == m_val[i]) begin
          m_run[i] = 0;
        end else if (m_tick) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == CNT) begin
            nv[i] = m_in2[i];
            m_run[i] = 0;
          end
        end
      end
      m_pend = (m_pend & ~bus.pend_clr) | (nv & ~m_val & bus.rise_en)
             | (~nv & m_val & bus.fall_en);
      m_val = nv;
      m_in2 = m_in1;
      m_in1 = bus.gpio_in_buf;
      age++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("gpio_val", 32'(bus.gpio_val), 32'(m_val));
      check("pend",     32'(bus.pend),     32'(m_pend));
      check("irq",      32'(bus.irq),      32'(|m_pend));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n;
  int idx;

  initial begin
    rstn            = 1'b0;
    bus.gpio_in_buf = '1;
    bus.db_en       = '0;
    bus.rise_en     = '0;
    bus.fall_en     = '0;
    bus.pend_clr    = '0;
    step(1);
    chk_en = 1'b1;

    // Reset with all inputs high, then 3-clock bypass latency.
    step(2);
    check("rst_val",  32'(bus.gpio_val), 32'h0);
    check("rst_pend", 32'(bus.pend),     32'h0);
    check("rst_irq",  32'(bus.irq),      32'h0);
    rstn = 1'b1;
    step(2);
    check("lat_2clk", 32'(bus.gpio_val), 32'h0);
    step(1);
    check("lat_3clk", 32'(bus.gpio_val), 32'h7FFFF);
    check("no_pend_after_rst", 32'(bus.pend), 32'h0);

    // Bypass rising edge on bit4, then write-1-to-clear.
    bus.gpio_in_buf = '0;
    step(5);
    bus.rise_en = vec_t'(1) << 4;
    bus.gpio_in_buf[4] = 1'b1;
    step(2);
    check("b4_pend_c2", 32'(bus.pend[4]), 32'h0);
    step(1);
    check("b4_val_c3",  32'(bus.gpio_val[4]), 32'h1);
    check("b4_pend_c3", 32'(bus.pend[4]),     32'h1);
    check("b4_irq_c3",  32'(bus.irq),         32'h1);
    step(7);
    bus.pend_clr = vec_t'(1) << 4;
    step(1);
    bus.pend_clr = '0;
    check("b4_pend_clr", 32'(bus.pend[4]), 32'h0);
    check("b4_irq_clr",  32'(bus.irq),     32'h0);

    // Debounced bit7: acceptance after three ticks.
    bus.db_en[7] = 1'b1;
    bus.rise_en[7] = 1'b1;
    bus.gpio_in_buf[7] = 1'b1;
    n = 0;
    while (bus.gpio_val[7] == 1'b0 && n < 60) begin
      step(1);
      n++;
    end
    check("b7_db_latency_in_35_51", 32'(n >= 35 && n <= 51), 32'h1);
    check("b7_pend", 32'(bus.pend[7]), 32'h1);
    bus.pend_clr = vec_t'(1) << 7;
    step(1);
    bus.pend_clr = '0;
    bus.gpio_in_buf[7] = 1'b0;
    n = 0;
    while (bus.gpio_val[7] == 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    check("b7_db_fall_in_35_51", 32'(n >= 35 && n <= 51), 32'h1);
    // 20-clock pulse spans at most two ticks: rejected.
    bus.gpio_in_buf[7] = 1'b1;
    step(20);
    bus.gpio_in_buf[7] = 1'b0;
    step(60);
    check("b7_pulse_val",  32'(bus.gpio_val[7]), 32'h0);
    check("b7_pulse_pend", 32'(bus.pend[7]),     32'h0);

    // Bit0 falling edge with a same-cycle clear: set wins.
    bus.gpio_in_buf[0] = 1'b1;
    step(5);
    bus.fall_en[0] = 1'b1;
    bus.gpio_in_buf[0] = 1'b0;
    step(2);
    bus.pend_clr[0] = 1'b1;
    step(1);
    bus.pend_clr = '0;
    check("b0_set_wins", 32'(bus.pend[0]), 32'h1);
    bus.pend_clr[0] = 1'b1;
    step(1);
    bus.pend_clr = '0;
    check("b0_cleared", 32'(bus.pend[0]), 32'h0);

    // Bit2: edges with disabled capture are not remembered.
    bus.gpio_in_buf[2] = 1'b1;
    step(5);
    bus.rise_en[2] = 1'b1;
    step(3);
    check("b2_no_retro_rise", 32'(bus.pend[2]), 32'h0);
    bus.fall_en[2] = 1'b0;
    bus.gpio_in_buf[2] = 1'b0;
    step(5);
    check("b2_no_fall", 32'(bus.pend[2]), 32'h0);

    // Bit9: reset mid-debounce discards two counted ticks.
    bus.db_en[9] = 1'b1;
    rstn = 1'b0;
    bus.gpio_in_buf[9] = 1'b1;
    step(1);
    rstn = 1'b1;
    step(40);
    check("b9_before_rst", 32'(bus.gpio_val[9]), 32'h0);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    step(47);
    check("b9_fresh_47", 32'(bus.gpio_val[9]), 32'h0);
    step(1);
    check("b9_fresh_48", 32'(bus.gpio_val[9]), 32'h1);

    // Randomized traffic, checked by the per-cycle compare.
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        bus.db_en   = vec_t'($urandom);
        bus.rise_en = vec_t'($urandom);
        bus.fall_en = vec_t'($urandom);
      end
      if ($urandom_range(7, 0) == 0) begin
        idx = int'($urandom_range(NB - 1, 0));
        bus.gpio_in_buf[idx] = ~bus.gpio_in_buf[idx];
      end
      bus.pend_clr = ($urandom_range(3, 0) == 0) ? vec_t'($urandom & $urandom) : '0;
      rstn = ($urandom_range(1999, 0) == 0) ? 1'b0 : 1'b1;
      step(1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
